// File: rtl/ca_pkg.sv
// Shared definitions for the 4-cell hybrid CA sequence generator and checker.
// Words are [0:3] with cell 0 as the numeric MSB, so seed 0001 steps to 0010.
package ca_pkg;

  localparam int                  CA_W      = 4;
  localparam logic [0:CA_W-1]     CA_SEED   = 4'b0001;
  localparam int                  CA_PERIOD = 15;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ca_state_e;

  function automatic logic [0:CA_W-1] ca_next(input logic [0:CA_W-1] s);
    logic [0:CA_W-1] n;
    n[0] = s[0] ^ s[1];
    n[1] = s[0] ^ s[2];
    n[2] = s[1] ^ s[2] ^ s[3];
    n[3] = s[2];
    return n;
  endfunction

endpackage

// File: rtl/ca_step.sv
// One combinational step of the hybrid CA.
module ca_step
  import ca_pkg::*;
(
  input  logic [0:CA_W-1] s,
  output logic [0:CA_W-1] n
);

  assign n = ca_next(s);

endmodule

// File: rtl/ca_seq_checker.sv
// Receive-side CA sequence checker: hunts for the sequence, locks, then
// flywheels its own state and counts mismatching words.
module ca_seq_checker
  import ca_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:CA_W-1]  in_data,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [0:CA_W-1]  expected
);

  ca_state_e        state_reg, state_next;
  logic [0:CA_W-1]  exp_reg, exp_next;
  logic [3:0]       match_reg, match_next;
  logic [3:0]       miss_reg, miss_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             miss_hit;
  logic [0:CA_W-1]  seed_step, fly_step;

  // Seed path reloads from the received word; flywheel path advances our own state.
  ca_step u_seed_step (.s(in_data), .n(seed_step));
  ca_step u_fly_step  (.s(exp_reg), .n(fly_step));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= HUNT;
      exp_reg   <= '0;
      match_reg <= '0;
      miss_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      exp_reg   <= exp_next;
      match_reg <= match_next;
      miss_reg  <= miss_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    exp_next   = exp_reg;
    match_next = match_reg;
    miss_next  = miss_reg;
    err_next   = 1'b0;
    miss_hit   = 1'b0;
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (in_data != '0) begin
            exp_next   = seed_step;
            match_next = '0;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (in_data == '0) begin
            state_next = HUNT;
            exp_next   = '0;
            match_next = '0;
          end else if (in_data == exp_reg) begin
            exp_next = fly_step;
            if (match_reg == 4'(LOCK_CNT - 1)) begin
              state_next = LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_reg + 4'd1;
            end
          end else begin
            exp_next   = seed_step;
            match_next = '0;
          end
        end
        LOCKED: begin
          exp_next = fly_step;
          if (in_data == exp_reg) begin
            miss_next = '0;
          end else begin
            miss_hit = 1'b1;
            err_next = 1'b1;
            if (miss_reg == 4'(UNLOCK_CNT - 1)) begin
              state_next = HUNT;
              exp_next   = '0;
              miss_next  = '0;
            end else begin
              miss_next = miss_reg + 4'd1;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // A clear coinciding with a counted miss leaves exactly that miss in the count.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt)
      cnt_next = miss_hit ? CNT_W'(1) : '0;
    else if (miss_hit && cnt_reg != '1)
      cnt_next = cnt_reg + CNT_W'(1);
  end

  assign locked    = (state_reg == LOCKED);
  assign err       = err_reg;
  assign err_count = cnt_reg;
  assign expected  = exp_reg;

endmodule
